// File: rtl/adder_error_evaluator.sv
// Exhaustive error sweep for a W-bit approximate adder: drives every operand pair,
// compares the CUT sum with the exact sum and accumulates count/max/sum of |error|.
module adder_error_evaluator #(
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  output logic [W-1:0]   op_a_o,
  output logic [W-1:0]   op_b_o,
  output logic           vec_valid_o,
  input  logic [W:0]     approx_sum_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*W:0]   err_count_o,
  output logic [W:0]     max_err_o,
  output logic [3*W:0]   sum_abs_err_o,
  output logic [1:0]     state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2*W-1:0] CNT_LAST = '1;
  localparam logic [2*W-1:0] CNT_ONE  = {{(2*W-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [2*W-1:0] cnt_q, cnt_d;
  logic           clear;

  logic           s1_valid_q;
  logic [W:0]     s1_exact_q, s1_approx_q;
  logic [W:0]     err;

  logic [2*W:0]   err_count_q, err_count_d;
  logic [W:0]     max_err_q, max_err_d;
  logic [3*W:0]   sum_abs_err_q, sum_abs_err_d;

  // Valid/ready: there is no back-pressure; a vector is consumed in every cycle
  // vec_valid_o is high, and approx_sum_i must be settled within that cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
          clear   = 1'b1;
        end
      end
      S_SWEEP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = S_DRAIN;
      end
      // The last vector's stage-2 update lands on the edge leaving DRAIN.
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign op_a_o      = cnt_q[2*W-1:W];
  assign op_b_o      = cnt_q[W-1:0];
  assign vec_valid_o = (state_q == S_SWEEP);
  assign busy_o      = (state_q == S_SWEEP) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);
  assign state_o     = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
    end else begin
      s1_valid_q  <= vec_valid_o;
      s1_exact_q  <= {1'b0, op_a_o} + {1'b0, op_b_o};
      s1_approx_q <= approx_sum_i;
    end
  end

  assign err = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                           : (s1_approx_q - s1_exact_q);

  always_comb begin
    err_count_d   = err_count_q;
    max_err_d     = max_err_q;
    sum_abs_err_d = sum_abs_err_q;
    if (clear) begin
      err_count_d   = '0;
      max_err_d     = '0;
      sum_abs_err_d = '0;
    end else if (s1_valid_q) begin
      err_count_d   = err_count_q + {{(2*W){1'b0}}, (err != '0)};
      max_err_d     = (err > max_err_q) ? err : max_err_q;
      sum_abs_err_d = sum_abs_err_q + {{(2*W){1'b0}}, err};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_count_q   <= '0;
      max_err_q     <= '0;
      sum_abs_err_q <= '0;
    end else begin
      err_count_q   <= err_count_d;
      max_err_q     <= max_err_d;
      sum_abs_err_q <= sum_abs_err_d;
    end
  end

  assign err_count_o   = err_count_q;
  assign max_err_o     = max_err_q;
  assign sum_abs_err_o = sum_abs_err_q;

endmodule
